// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b (a + ~b + 1), one bit per clock, LSB first
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, bo_q, bo_d, ov_q, ov_d, done_q, done_d;
  logic             sum, cout;
  assign sum  = a_q[0] ^ b_q[0] ^ c_q;
  assign cout = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    ov_d    = ov_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = SHIFT;
        a_d     = a;
        b_d     = ~b;
        c_d     = 1'b1;
        cnt_d   = '0;
      end
    end else begin
      res_d = {sum, res_q[WIDTH-1:1]};
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      c_d   = cout;
      cnt_d = cnt_q + CW'(1);
      // c_q here is the carry into the MSB
      if (cnt_q == CW'(WIDTH-1)) begin
        state_d = IDLE;
        diff_d  = res_d;
        bo_d    = ~cout;
        ov_d    = c_q ^ cout;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
    end
  end
  assign busy      = (state_q == SHIFT);
  assign done      = done_q;
  assign diff      = diff_q;
  assign borrowout = bo_q;
  assign overflow  = ov_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized + directed scoreboard bench against an arithmetic reference
module tb_serial_subtractor;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, borrowout, overflow;
  logic [W-1:0] diff;
  int           checks = 0, errors = 0, cyc = 0;
  logic [W+1:0] exp_q[$];
  int           acc_q[$];
  logic [W+1:0] hold = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrowout(borrowout), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    logic         bo, ov;
    d  = x - y;
    bo = x < y;
    ov = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
    return {d, bo, ov};
  endfunction

  // scoreboard: push on every accepted start, pop and compare on every done
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      hold = '0;
      check("reset_outputs", {busy, done, diff, borrowout, overflow}, '0);
    end else begin
      if (done) begin
        if (exp_q.size() == 0) check("spurious_done", 1, 0);
        else begin
          hold = exp_q.pop_front();
          check("diff", diff, hold[W+1:2]);
          check("borrowout", borrowout, hold[1]);
          check("overflow", overflow, hold[0]);
          check("latency", cyc - acc_q.pop_front(), W);
          check("busy_at_done", busy, 0);
        end
      end else begin
        check("held_results", {diff, borrowout, overflow}, hold);
      end
      if (start && !busy) begin
        exp_q.push_back(model(a, b));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3 * W) begin
      step();
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
    wait_idle();
    a = x;
    b = y;
    start = 1'b1;
    step();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(10);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    op(4'b0101, 4'b0011);
    op(4'b0011, 4'b0101);
    op(4'b0000, 4'b0000);
    op(4'b0111, 4'b1111);
    op(4'b1000, 4'b0001);
    step(W + 2);
    // start pulsed while busy must be ignored
    op(4'b0101, 4'b0011);
    step();
    a = 4'b1111;
    b = 4'b0000;
    start = 1'b1;
    step();
    start = 1'b0;
    step(W + 3);
    check("protect_diff", diff, 4'b0010);
    // held start: two ops, second accepted on the done cycle
    a = 4'b1001;
    b = 4'b0001;
    start = 1'b1;
    step();
    a = 4'b0001;
    b = 4'b0010;
    step(W + 1);
    start = 1'b0;
    step(W + 2);
    check("b2b_diff", diff, 4'b1111);
    check("queue_empty_b2b", exp_q.size(), 0);
    // asynchronous reset mid-operation
    op(4'b1100, 4'b0001);
    step();
    rst_n = 1'b0;
    #1;
    check("async_reset", {busy, done, diff, borrowout, overflow}, '0);
    step(2);
    rst_n = 1'b1;
    step();
    op(4'b0110, 4'b0010);
    step(W + 2);
    check("post_reset_diff", diff, 4'b0100);
    // random traffic with random gaps and occasional held start
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom;
        b = $urandom;
        start = 1'b1;
        step($urandom_range(1, 2 * W + 2));
        start = 1'b0;
      end else begin
        op($urandom, $urandom);
        step($urandom_range(0, W + 2));
      end
    end
    step(2 * W + 4);
    check("queue_empty_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
